// File: rtl/eq_sweep_checker.sv
// rtl/eq_sweep_checker.sv - clocked 16-vector stimulus/response checker for a 4-input equation block (option: STOP_ON_FAIL_EN)
module eq_sweep_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int          SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       first_fail_vld
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [4:0] err_next;
    logic       stop_now;

    // The vector comes straight from the idx register, so the stimulus never glitches
    assign {a, b, c, d} = idx;

    assign mismatch = (o != EXPECTED[idx]);
    assign err_next = err_count + {4'b0000, mismatch};

`ifdef STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Sweep sequencer: hold each vector SETTLE cycles, sample once, advance or finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail     <= 4'd0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= DRIVE;
                        idx            <= 4'd0;
                        settle_cnt     <= 4'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 5'd0;
                        first_fail     <= 4'd0;
                        first_fail_vld <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_fail_vld) begin
                            first_fail     <= idx;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (idx == 4'hF || stop_now) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        idx        <= idx + 4'd1;
                        settle_cnt <= 4'd0;
                        state      <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_sweep_checker.sv
// tb/tb_eq_sweep_checker.sv - table-driven scoreboard bench for eq_sweep_checker
module tb_eq_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, c, d;
    logic       o;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       first_fail_vld;
    logic [15:0] resp_cur;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Response model of the equation block: table lookup on the driven vector
    assign o = resp_cur[{a, b, c, d}];

    eq_sweep_checker #(.EXPECTED(16'h6996), .SETTLE(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .o              (o),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    typedef struct {
        logic [15:0] resp;
        int          err;
        int          ff;
        bit          ffv;
        bit          pass_e;
    } vec_t;

    typedef struct {
        int err;
        int ff;
        bit ffv;
        bit pass_e;
        int cycles;
        int final_vec;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One sweep from a start pulse to done; optionally fires ignored starts at cycles 5 and 30
    task automatic run_sweep(input vec_t v, input bit inject);
        exp_t e;
        exp_t got;
        int   bad_vec = 0;
        int   bad_busy = 0;
        int   cyc = -1;
        e.err = v.err; e.ff = v.ff; e.ffv = v.ffv; e.pass_e = v.pass_e;
        e.cycles = 48; e.final_vec = 15;
`ifdef STOP_ON_FAIL_EN
        if (v.err > 0) begin
            e.err = 1;
            e.cycles = (v.ff + 1) * 3;
            e.final_vec = v.ff;
        end
`endif
        resp_cur = v.resp;
        @(negedge clk); start = 1'b1;
        sb.push_back(e);
        @(negedge clk); start = 1'b0;
        chk("start_clears", {busy, done, pass, first_fail_vld, err_count, a, b, c, d},
            {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
        for (int j = 1; j <= 100; j++) begin
            if (inject && (j == 5 || j == 30)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = j;
                break;
            end
            if ({a, b, c, d} != 4'(j / 3)) bad_vec++;
            if (!busy) bad_busy++;
        end
        got = sb.pop_front();
        chk("timeout", (cyc > 0) ? 1 : 0, 1);
        chk("done_cycle", cyc, got.cycles);
        chk("vector_seq_bad_cycles", bad_vec, 0);
        chk("busy_bad_cycles", bad_busy, 0);
        chk("err_count", err_count, got.err);
        chk("first_fail_vld", first_fail_vld, got.ffv);
        if (got.ffv) chk("first_fail", first_fail, got.ff);
        chk("pass", pass, got.pass_e);
        repeat (2) @(negedge clk);
        chk("done_hold", {done, busy}, 2'b10);
        chk("final_vector", {a, b, c, d}, got.final_vec);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{16'h6996, 0,  0,  1'b0, 1'b1};
        tbl[1] = '{16'h0000, 8,  1,  1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 8,  0,  1'b1, 1'b0};
        tbl[3] = '{16'h6997, 1,  0,  1'b1, 1'b0};
        tbl[4] = '{16'hE996, 1,  15, 1'b1, 1'b0};
        tbl[5] = '{16'h9669, 16, 0,  1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; resp_cur = 16'h6996;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {busy, done, pass, first_fail_vld, err_count, first_fail, a, b, c, d}, 0);
        repeat (2) @(negedge clk);
        chk("idle_no_start", {busy, done}, 0);

        for (int i = 0; i < 6; i++) run_sweep(tbl[i], 1'b0);

        // Restarts fired mid-sweep must be ignored
        run_sweep(tbl[1], 1'b1);

        // Reset at cycle 20 aborts the sweep and clears partial results
        resp_cur = 16'h0000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_sweep_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_abort", {busy, done, pass, first_fail_vld, err_count, first_fail, a, b, c, d}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stays_idle", {busy, done}, 0);
        run_sweep(tbl[0], 1'b0);
        run_sweep(tbl[2], 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
